// File: rtl/ofdm_sym_sched.sv
// OFDM symbol scheduler feeding add_cp.
// Pulls N_FFT samples per symbol, leaves CP_LEN idle cycles, IFG after each frame.
module ofdm_sym_sched #(
  parameter int W             = 12,
  parameter int N_FFT         = 1024,
  parameter int CP_LEN        = 32,
  parameter int SYM_PER_FRAME = 8,
  parameter int IFG_LEN       = 64,
  localparam int SW = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [W-1:0]  src_real,
  input  logic [W-1:0]  src_imag,
  output logic          osop,
  output logic          oval,
  output logic [W-1:0]  out_real,
  output logic [W-1:0]  out_imag,
  output logic [SW-1:0] sym_idx,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);

  localparam int MX1 = (N_FFT > CP_LEN) ? N_FFT : CP_LEN;
  localparam int MX  = (MX1 > IFG_LEN) ? MX1 : IFG_LEN;
  localparam int CW  = (MX > 1) ? $clog2(MX) : 1;

  localparam logic [CW-1:0] N_LAST = CW'(N_FFT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CP_LEN - 1);
  localparam logic [CW-1:0] I_LAST = CW'(IFG_LEN - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SYM_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    GAP,
    IFG
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          pend;

  assign src_ready = (state == DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sym_idx    <= '0;
      pend       <= 1'b0;
      osop       <= 1'b0;
      oval       <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      osop       <= 1'b0;
      oval       <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      frame_done <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        cnt     <= '0;
        sym_idx <= '0;
        pend    <= 1'b0;
        busy    <= 1'b0;
      end else begin
        if (start && state != IDLE)
          pend <= 1'b1;
        unique case (state)
          IDLE: begin
            if (start) begin
              state   <= DATA;
              cnt     <= '0;
              sym_idx <= '0;
              busy    <= 1'b1;
            end else begin
              busy    <= 1'b0;
            end
          end
          DATA: begin
            // a missing sample becomes zero so the symbol slot never stretches
            oval <= 1'b1;
            osop <= (cnt == '0);
            if (src_valid) begin
              out_real <= src_real;
              out_imag <= src_imag;
            end else begin
              underrun <= 1'b1;
            end
            if (cnt == N_LAST) begin
              state <= GAP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == C_LAST) begin
              cnt <= '0;
              if (sym_idx == S_LAST) begin
                state <= IFG;
              end else begin
                sym_idx <= sym_idx + 1'b1;
                state   <= DATA;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          IFG: begin
            if (cnt == I_LAST) begin
              frame_done <= 1'b1;
              cnt        <= '0;
              sym_idx    <= '0;
              // a start landing on this very cycle still chains the next frame
              if (pend || start) begin
                state <= DATA;
                pend  <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ofdm_sym_sched.sv
// Bench for ofdm_sym_sched: frame-timeline model plus directed and random stimulus.
module tb_ofdm_sym_sched;

  localparam int W   = 12;
  localparam int N   = 1024;
  localparam int CP  = 32;
  localparam int SYM = 8;
  localparam int IFG = 64;
  localparam int SW  = $clog2(SYM);
  localparam int SL  = N + CP;
  localparam int F   = SYM * SL + IFG;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [W-1:0]  src_real = '0;
  logic [W-1:0]  src_imag = '0;
  logic          osop;
  logic          oval;
  logic [W-1:0]  out_real;
  logic [W-1:0]  out_imag;
  logic [SW-1:0] sym_idx;
  logic          busy;
  logic          frame_done;
  logic          underrun;

  ofdm_sym_sched #(
    .W(W), .N_FFT(N), .CP_LEN(CP),
    .SYM_PER_FRAME(SYM), .IFG_LEN(IFG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_real(src_real), .src_imag(src_imag),
    .osop(osop), .oval(oval),
    .out_real(out_real), .out_imag(out_imag),
    .sym_idx(sym_idx), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
    end
  endtask

  // Frame-timeline model: a frame starting at cycle fs has its
  // DATA cycles at offsets p where p < SYM*SL and p%SL < N.
  int cyc = 0;
  bit m_act = 1'b0;
  bit m_pend = 1'b0;
  int m_fs = 0;
  int e_osop = 0, e_oval = 0, e_re = 0, e_im = 0;
  int e_sym = 0, e_busy = 0, e_done = 0, e_ur = 0;

  initial begin
    int p;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_act = 0; m_pend = 0;
        e_osop = 0; e_oval = 0; e_re = 0; e_im = 0;
        e_sym = 0; e_busy = 0; e_done = 0; e_ur = 0;
      end else begin
        e_osop = 0; e_oval = 0; e_re = 0; e_im = 0; e_done = 0;
        if (m_act) begin
          p = cyc - m_fs;
          if (abort) begin
            m_act = 0; m_pend = 0; e_busy = 0; e_sym = 0;
          end else begin
            if (start) m_pend = 1;
            if (p < SYM * SL && p % SL < N) begin
              e_oval = 1;
              e_osop = (p % SL == 0) ? 1 : 0;
              if (src_valid) begin
                e_re = int'(src_real);
                e_im = int'(src_imag);
              end else begin
                e_ur = 1;
              end
            end
            if (p == F - 1) begin
              e_done = 1;
              e_sym = 0;
              if (m_pend) begin
                m_fs = cyc + 1;
                m_pend = 0;
              end else begin
                m_act = 0;
              end
            end else begin
              e_sym = ((p + 1) / SL < SYM) ? (p + 1) / SL : SYM - 1;
            end
          end
        end else if (start) begin
          m_act = 1; m_fs = cyc + 1; e_busy = 1; e_sym = 0;
        end else begin
          e_busy = 0;
        end
        cyc++;
      end
    end
  end

  int oval_cnt = 0;
  int done_cnt = 0;
  int busy0_cnt = 0;

  initial begin
    int p, rdy_e;
    forever begin
      @(negedge clk);
      p = cyc - m_fs;
      rdy_e = (m_act && p >= 0 && p < SYM * SL && p % SL < N) ? 1 : 0;
      check("src_ready", 32'(src_ready), rdy_e);
      check("osop", 32'(osop), e_osop);
      check("oval", 32'(oval), e_oval);
      check("out_real", 32'(out_real), e_re);
      check("out_imag", 32'(out_imag), e_im);
      check("sym_idx", 32'(sym_idx), e_sym);
      check("busy", 32'(busy), e_busy);
      check("frame_done", 32'(frame_done), e_done);
      check("underrun", 32'(underrun), e_ur);
      if (oval) oval_cnt++;
      if (frame_done) done_cnt++;
      if (!busy) busy0_cnt++;
    end
  end

  bit rnd = 1'b0;
  bit vld = 1'b1;
  int rc = 0;
  int p_now = 0;

  task automatic tick();
    @(negedge clk);
    if (rnd) begin
      src_valid = ($urandom_range(0, 19) != 0);
      src_real  = W'($urandom);
      src_imag  = W'($urandom);
    end else begin
      src_valid = vld;
      src_real  = W'(rc);
      src_imag  = W'(N - 1 - rc);
      if (src_ready) rc = (rc + 1) % N;
    end
    p_now++;
  endtask

  task automatic start_frame();
    tick();
    start = 1'b1;
    rc = 0;
    tick();
    start = 1'b0;
    p_now = 0;
    oval_cnt = 0;
    done_cnt = 0;
    busy0_cnt = 0;
  endtask

  task automatic run_to(input int t);
    while (p_now < t) tick();
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (10) tick();
    rst = 1'b0;
    tick();
    check("rst_oval", 32'(oval), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(src_ready), 0);

    // single clean frame with ramp data
    start_frame();
    tick();
    check("t1_osop", 32'(osop), 1);
    check("t1_first_re", 32'(out_real), 0);
    run_to(SL + 1);
    check("t1_osop_s1", 32'(osop), 1);
    check("t1_sym1", 32'(sym_idx), 1);
    run_to(F);
    check("t1_done", 32'(frame_done), 1);
    check("t1_busy_at_done", 32'(busy), 1);
    tick();
    check("t1_busy_fall", 32'(busy), 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_oval_cnt", oval_cnt, SYM * N);
    check("t1_underrun", 32'(underrun), 0);

    // underrun on samples 100..103 of symbol 3
    start_frame();
    run_to(3 * SL + 99);
    vld = 1'b0;
    tick();
    check("t2_pre_re", 32'(out_real), 99);
    check("t2_pre_ur", 32'(underrun), 0);
    run_to(3 * SL + 103);
    vld = 1'b1;
    tick();
    check("t2_zero_re", 32'(out_real), 0);
    check("t2_zero_im", 32'(out_imag), 0);
    check("t2_oval", 32'(oval), 1);
    check("t2_ur", 32'(underrun), 1);
    run_to(F + 1);
    check("t2_ur_sticky", 32'(underrun), 1);
    check("t2_oval_cnt", oval_cnt, SYM * N);
    check("t2_done_cnt", done_cnt, 1);

    // back-to-back frames
    start_frame();
    run_to(5 * SL + 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(F);
    check("t3_done1", 32'(frame_done), 1);
    tick();
    check("t3_osop2", 32'(osop), 1);
    check("t3_sym2", 32'(sym_idx), 0);
    run_to(2 * F);
    check("t3_done2", 32'(frame_done), 1);
    check("t3_done_cnt", done_cnt, 2);
    check("t3_busy_gap", busy0_cnt, 0);
    tick();
    check("t3_busy_fall", 32'(busy), 0);
    check("t3_oval_cnt", oval_cnt, 2 * SYM * N);

    // abort mid symbol 2, with a simultaneous start that must be dropped
    start_frame();
    run_to(2 * SL + 500);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("t4_oval", 32'(oval), 0);
    check("t4_ready", 32'(src_ready), 0);
    check("t4_sym", 32'(sym_idx), 0);
    check("t4_busy", 32'(busy), 0);
    run_to(2 * SL + 520);
    check("t4_idle", 32'(busy), 0);
    check("t4_no_done", done_cnt, 0);
    start_frame();
    tick();
    check("t4_restart_osop", 32'(osop), 1);
    check("t4_restart_sym", 32'(sym_idx), 0);
    run_to(50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();

    // asynchronous reset mid DATA
    start_frame();
    run_to(300);
    check("t5_ur_before", 32'(underrun), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_ready", 32'(src_ready), 0);
    check("t5_osop", 32'(osop), 0);
    check("t5_oval", 32'(oval), 0);
    check("t5_re", 32'(out_real), 0);
    check("t5_im", 32'(out_imag), 0);
    check("t5_sym", 32'(sym_idx), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(frame_done), 0);
    check("t5_ur", 32'(underrun), 0);
    repeat (3) tick();
    rst = 1'b0;
    oval_cnt = 0;
    repeat (100) tick();
    check("t5_idle_oval", oval_cnt, 0);
    check("t5_idle_busy", 32'(busy), 0);

    // random traffic: sparse starts/aborts, 5% source underruns
    rnd = 1'b1;
    tick();
    start = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      tick();
      start = ($urandom_range(0, 2999) == 0);
      abort = ($urandom_range(0, 9999) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    rnd = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
